fp_md_ctrl: RTL and testbench

FP_MD_CTRL -- requirements
Module: fp_md_ctrl

---
 rtl/fp_md_ctrl.sv | 65 ++++++
 tb/tb_fp_md_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/fp_md_ctrl.sv
// fp_md_ctrl: sequencing FSM for an FP multiply/divide datapath
// (unpack, multiply or iterative divide, normalize, round, result hold).
module fp_md_ctrl #(
    parameter int MUL_LAT   = 1,
    parameter int DIV_ITERS = 26
) (
    input  logic clk,
    input  logic arst,
    input  logic flush,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_op,
    input  logic req_special,
    output logic unpack_en,
    output logic mul_en,
    output logic div_en,
    output logic div_first,
    output logic norm_en,
    output logic round_en,
    output logic res_valid,
    input  logic res_ready,
    output logic res_op,
    output logic res_special,
    output logic busy
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, NORM, ROUND, HOLD} state_t;
    localparam logic [5:0] MUL_LOAD = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_ITERS - 1);
    state_t state;
    logic [5:0] cnt;
    // enables are pure state decodes, gated only by flush so an abort kills them at once
    assign req_ready = state == IDLE && !flush;
    assign unpack_en = req_valid && req_ready;
    assign mul_en    = state == MUL && !flush;
    assign div_en    = state == DIV && !flush;
    assign div_first = div_en && cnt == DIV_LOAD;
    assign norm_en   = state == NORM && !flush;
    assign round_en  = state == ROUND && !flush;
    assign res_valid = state == HOLD;
    assign busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= IDLE;
            cnt         <= '0;
            res_op      <= 1'b0;
            res_special <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    res_op      <= req_op;
                    res_special <= req_special;
                    cnt         <= req_op ? DIV_LOAD : MUL_LOAD;
                    state       <= req_special ? HOLD : req_op ? DIV : MUL;
                end
                MUL, DIV: if (cnt == 0) state <= NORM; else cnt <= cnt - 1'b1;
                NORM:  state <= ROUND;
                ROUND: state <= HOLD;
                HOLD:  if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_md_ctrl.sv
// tb_fp_md_ctrl: directed and random stimulus checked every cycle against
// a schedule model (cycles since accept -> expected stage outputs).
module tb_fp_md_ctrl;
    localparam int MUL_LAT   = 1;
    localparam int DIV_ITERS = 26;
    logic clk = 0;
    logic arst, flush, req_valid, req_op, req_special, res_ready;
    logic req_ready, unpack_en, mul_en, div_en, div_first, norm_en, round_en;
    logic res_valid, res_op, res_special, busy;
    int checks = 0, errors = 0;
    bit m_act;
    int m_k;
    logic m_op, m_sp;

    fp_md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITERS(DIV_ITERS)) dut (
        .clk(clk), .arst(arst), .flush(flush), .req_valid(req_valid),
        .req_ready(req_ready), .req_op(req_op), .req_special(req_special),
        .unpack_en(unpack_en), .mul_en(mul_en), .div_en(div_en),
        .div_first(div_first), .norm_en(norm_en), .round_en(round_en),
        .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op),
        .res_special(res_special), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, rv, op, sp, fl, rr, input string tag);
        int l, d;
        logic [10:0] got, exp;
        @(negedge clk);
        arst = r; req_valid = rv; req_op = op; req_special = sp; flush = fl; res_ready = rr;
        #1;
        l = m_sp ? 0 : (m_op ? DIV_ITERS : MUL_LAT);
        d = m_sp ? 1 : l + 3;
        if (m_act)
            exp = {1'b0, 1'b0,
                   !m_sp && !m_op && m_k <= l && !fl,
                   !m_sp && m_op && m_k <= l && !fl,
                   !m_sp && m_op && m_k == 1 && !fl,
                   !m_sp && m_k == l + 1 && !fl,
                   !m_sp && m_k == l + 2 && !fl,
                   m_k >= d, 1'b1, m_op, m_sp};
        else
            exp = {!fl, rv && !fl, 7'b0, m_op, m_sp};
        got = {req_ready, unpack_en, mul_en, div_en, div_first, norm_en, round_en,
               res_valid, busy, res_op, res_special};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0t got %b exp %b", tag, $time, got, exp);
        end
        if (r) begin
            m_act = 0; m_op = 0; m_sp = 0;
        end else if (fl) m_act = 0;
        else if (!m_act && rv) begin
            m_act = 1; m_k = 1; m_op = op; m_sp = sp;
        end else if (m_act) begin
            if (m_k >= d && rr) m_act = 0; else m_k++;
        end
    endtask

    initial begin
        arst = 1; flush = 0; req_valid = 0; req_op = 0; req_special = 0; res_ready = 0;
        repeat (2) @(posedge clk);
        m_act = 0; m_op = 0; m_sp = 0; m_k = 0;
        step(0, 0, 0, 0, 0, 0, "reset_state");
        // multiply, minimum latency
        step(0, 1, 0, 0, 0, 0, "mul_accept");
        repeat (4) step(0, 0, 0, 0, 0, 0, "mul_run");
        step(0, 0, 0, 0, 0, 1, "mul_consume");
        step(0, 0, 0, 0, 0, 0, "mul_idle");
        // divide
        step(0, 1, 1, 0, 0, 0, "div_accept");
        repeat (29) step(0, 0, 0, 0, 0, 0, "div_run");
        step(0, 0, 0, 0, 0, 1, "div_consume");
        // special skips compute
        step(0, 1, 1, 1, 0, 0, "spc_accept");
        step(0, 1, 0, 0, 0, 0, "spc_hold_ignore_req");
        step(0, 0, 0, 0, 0, 1, "spc_consume");
        // backpressure
        step(0, 1, 1, 0, 0, 0, "bp_accept");
        repeat (29) step(0, 0, 0, 0, 0, 0, "bp_run");
        repeat (10) step(0, 1, 0, 1, 0, 0, "bp_hold");
        step(0, 0, 0, 0, 0, 1, "bp_consume");
        step(0, 0, 0, 0, 0, 0, "bp_idle");
        // flush at divide iteration 10, then a clean multiply
        step(0, 1, 1, 0, 0, 0, "fl_accept");
        repeat (9) step(0, 0, 0, 0, 0, 0, "fl_div");
        step(0, 0, 0, 0, 1, 1, "fl_flush");
        repeat (3) step(0, 0, 0, 0, 0, 1, "fl_after");
        step(0, 1, 0, 0, 0, 0, "fl_mul_accept");
        repeat (4) step(0, 0, 0, 0, 0, 1, "fl_mul_run");
        // flush blocks an IDLE request
        step(0, 1, 1, 0, 1, 0, "fl_idle_req");
        step(0, 0, 0, 0, 0, 0, "fl_idle_after");
        // flush and consume together in HOLD
        step(0, 1, 1, 1, 0, 0, "fr_accept");
        step(0, 0, 0, 0, 1, 1, "fr_hold");
        step(0, 0, 0, 0, 0, 0, "fr_idle");
        // reset during HOLD with res_ready
        step(0, 1, 1, 1, 0, 0, "rst_accept");
        step(1, 0, 0, 0, 0, 1, "rst_hold");
        step(0, 0, 0, 0, 0, 0, "rst_after");
        // reset mid-divide
        step(0, 1, 1, 0, 0, 0, "rstd_accept");
        repeat (5) step(0, 0, 0, 0, 0, 0, "rstd_div");
        step(1, 0, 0, 0, 1, 1, "rstd_rst");
        step(0, 0, 0, 0, 0, 0, "rstd_after");
        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, "random");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
